round_timer_ctrl: RTL and testbench

Round sequencer for the game's time-left display. Owns the 1 Hz prescaler and a two-digit BCD seconds counter. Steps the round through idle, get-ready countdown, play and game-over. Drives the HEX0/HEX1 hex decoders and gives the game logic a round-active level and a time-up pulse.

---
 rtl/round_timer_ctrl_pkg.sv | 26 ++
 rtl/round_timer_ctrl_if.sv | 27 ++
 rtl/round_timer_ctrl_bcd_down_counter.sv | 47 ++++
 rtl/round_timer_ctrl.sv | 132 +++++++++++++
 tb/tb_round_timer_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/round_timer_ctrl_pkg.sv
// Shared types for the round timer: state encoding, BCD digit types and a
// helper that turns a 0..99 constant into two BCD digits.
package round_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    function automatic bcd2_t to_bcd2(input int unsigned v);
        bcd2_t r;
        r.tens = 4'((v / 10) % 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Signal bundle between the round timer and the game/display logic.
interface round_timer_ctrl_if;
    import round_timer_pkg::*;

    // No valid/ready pair here: Start and Pause are plain levels (only the
    // rising edge of Start acts); every output is a registered level, and
    // SecondTick/TimeUp are single-cycle pulses with no back-pressure.
    logic       Start;
    logic       Pause;
    bcd_t       OnesDigit;
    bcd_t       TensDigit;
    logic [1:0] State;
    logic       RoundActive;
    logic       SecondTick;
    logic       TimeUp;

    modport slave (
        input  Start, Pause,
        output OnesDigit, TensDigit, State, RoundActive, SecondTick, TimeUp
    );

    modport master (
        output Start, Pause,
        input  OnesDigit, TensDigit, State, RoundActive, SecondTick, TimeUp
    );

endinterface

// File: rtl/round_timer_ctrl_bcd_down_counter.sv
// Two-digit BCD down counter with clear, load and decrement; is_one flags 01.
module bcd_down_counter
    import round_timer_pkg::*;
#(
    parameter bcd2_t RESET_VALUE = '0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  load,
    input  bcd2_t load_value,
    input  logic  dec,
    output bcd2_t value,
    output logic  is_one
);

    bcd2_t value_q;
    bcd2_t value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_value;
        end else if (dec) begin
            if (value_q.ones == 4'd0) begin
                value_d.ones = 4'd9;
                value_d.tens = value_q.tens - 4'd1;
            end else begin
                value_d.ones = value_q.ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= RESET_VALUE;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign is_one = (value_q.tens == 4'd0) && (value_q.ones == 4'd1);

endmodule

// File: rtl/round_timer_ctrl.sv
// Round sequencer: 1 Hz prescaler plus IDLE/READY/PLAY/OVER FSM driving a BCD
// seconds display. Define ROUND_TIMER_PAUSE_EN to let Pause freeze the timer.
module round_timer_ctrl
    import round_timer_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int ROUND_SECONDS   = 60,
    parameter int READY_SECONDS   = 3
) (
    input  logic               ClockIn,
    input  logic               Reset,
    round_timer_ctrl_if.slave  bus
);

    localparam int                PRE_W      = $clog2(CLOCK_FREQUENCY);
    localparam logic [PRE_W-1:0]  PRE_RELOAD = PRE_W'(CLOCK_FREQUENCY - 1);
    localparam bcd2_t             ROUND_BCD  = to_bcd2(ROUND_SECONDS);
    localparam bcd2_t             READY_BCD  = to_bcd2(READY_SECONDS);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             start_prev_q;
    logic             second_tick_q, second_tick_d;
    logic             time_up_q, time_up_d;

    logic  hold;
    logic  start_edge;
    logic  running;
    logic  tick;
    logic  cnt_clear, cnt_load, cnt_dec, cnt_is_one;
    bcd2_t cnt_load_value, cnt_value;

`ifdef ROUND_TIMER_PAUSE_EN
    assign hold = bus.Pause;
`else
    logic unused_pause;
    assign unused_pause = bus.Pause;
    assign hold         = 1'b0;
`endif

    assign start_edge = bus.Start & ~start_prev_q;
    assign running    = ((state_q == ST_READY) || (state_q == ST_PLAY)) && !hold;
    assign tick       = running && (pre_q == '0);

    always_comb begin
        state_d        = state_q;
        pre_d          = pre_q;
        second_tick_d  = 1'b0;
        time_up_d      = 1'b0;
        cnt_clear      = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = ROUND_BCD;
        cnt_dec        = 1'b0;

        if (running) begin
            pre_d = tick ? PRE_RELOAD : pre_q - PRE_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                pre_d = PRE_RELOAD;
                if (start_edge) begin
                    state_d        = ST_READY;
                    cnt_load       = 1'b1;
                    cnt_load_value = READY_BCD;
                end
            end
            ST_READY: begin
                if (tick) begin
                    second_tick_d = 1'b1;
                    if (cnt_is_one) begin
                        state_d  = ST_PLAY;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // Start edges are deliberately dropped while a round runs.
                if (tick) begin
                    second_tick_d = 1'b1;
                    if (cnt_is_one) begin
                        state_d   = ST_OVER;
                        cnt_clear = 1'b1;
                        time_up_d = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            pre_q         <= PRE_RELOAD;
            start_prev_q  <= 1'b0;
            second_tick_q <= 1'b0;
            time_up_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            start_prev_q  <= bus.Start;
            second_tick_q <= second_tick_d;
            time_up_q     <= time_up_d;
        end
    end

    bcd_down_counter #(
        .RESET_VALUE (ROUND_BCD)
    ) u_digits (
        .clk        (ClockIn),
        .rst        (Reset),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .is_one     (cnt_is_one)
    );

    assign bus.OnesDigit   = cnt_value.ones;
    assign bus.TensDigit   = cnt_value.tens;
    assign bus.State       = state_q;
    assign bus.RoundActive = (state_q == ST_PLAY);
    assign bus.SecondTick  = second_tick_q;
    assign bus.TimeUp      = time_up_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl: directed vector table plus random stimulus,
// both checked every cycle against a seconds-level reference model.
module tb_round_timer_ctrl;

    localparam int CF    = 4;
    localparam int ROUND = 12;
    localparam int READY = 3;
    localparam int W     = 15;

`ifdef ROUND_TIMER_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic ClockIn;
    logic Reset;
    round_timer_ctrl_if bus ();

    round_timer_ctrl #(
        .CLOCK_FREQUENCY (CF),
        .ROUND_SECONDS   (ROUND),
        .READY_SECONDS   (READY)
    ) dut (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .bus     (bus.slave)
    );

    // clock / reset
    initial begin
        ClockIn = 1'b0;
        forever #5 ClockIn = ~ClockIn;
    end

    int n_compared = 0;
    int n_failed   = 0;

    // reference model: whole seconds and elapsed cycles within the second
    int m_state   = 0;
    int m_secs    = ROUND;
    int m_elapsed = 0;
    bit m_prev    = 1'b0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] pack(input int st, input int secs,
                                          input bit tk, input bit tu);
        return {2'(st), 4'(secs / 10), 4'(secs % 10), (st == 2), tk, tu};
    endfunction

    task automatic model_step(input bit rst, input bit start, input bit pause);
        bit tk = 1'b0;
        bit tu = 1'b0;
        if (rst) begin
            m_state = 0; m_secs = ROUND; m_elapsed = 0; m_prev = 1'b0;
        end else begin
            bit edge_seen = start && !m_prev;
            m_prev = start;
            if (m_state == 0 || m_state == 3) begin
                if (edge_seen) begin
                    m_state = 1; m_secs = READY; m_elapsed = 0;
                end
            end else if (!(PAUSE_EN && pause)) begin
                m_elapsed++;
                if (m_elapsed == CF) begin
                    m_elapsed = 0;
                    tk = 1'b1;
                    if (m_secs == 1) begin
                        if (m_state == 1) begin
                            m_state = 2; m_secs = ROUND;
                        end else begin
                            m_state = 3; m_secs = 0; tu = 1'b1;
                        end
                    end else begin
                        m_secs--;
                    end
                end
            end
        end
        exp_q.push_back(pack(m_state, m_secs, tk, tu));
    endtask

    function automatic logic [W-1:0] dut_vec();
        return {bus.State, bus.TensDigit, bus.OnesDigit,
                bus.RoundActive, bus.SecondTick, bus.TimeUp};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got st=%0d d=%h%h act=%b tick=%b tu=%b, want st=%0d d=%h%h act=%b tick=%b tu=%b",
                     name, got[14:13], got[12:9], got[8:5], got[4], got[3], got[2],
                     exp[14:13], exp[12:9], exp[8:5], exp[4], exp[3], exp[2]);
        end
    endtask

    // driver: apply inputs, clock once, score against the model
    task automatic run_cycle(input bit rst, input bit start, input bit pause,
                             input string tag);
        logic [W-1:0] exp;
        Reset     = rst;
        bus.Start = start;
        bus.Pause = pause;
        @(posedge ClockIn);
        model_step(rst, start, pause);
        #1;
        exp = exp_q.pop_front();
        check({"model ", tag}, dut_vec(), exp);
    endtask

    typedef struct {
        bit   rst;
        bit   start;
        bit   pause;
        int   n;
        int   st;
        int   tens;
        int   ones;
        bit   act;
        bit   tk;
        bit   tu;
        string name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rst, input bit start, input bit pause,
                                input int n, input int st, input int tens,
                                input int ones, input bit act, input bit tk,
                                input bit tu, input string name);
        vec_t v;
        v.rst = rst; v.start = start; v.pause = pause; v.n = n;
        v.st = st; v.tens = tens; v.ones = ones; v.act = act; v.tk = tk; v.tu = tu;
        v.name = name;
        return v;
    endfunction

    initial begin
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Pause = 1'b0;

        //                rst st ps  n  st t o act tk tu
        vecs.push_back(mk(1, 0, 0,  3, 0, 1, 2, 0, 0, 0, "reset"));
        vecs.push_back(mk(0, 0, 0, 20, 0, 1, 2, 0, 0, 0, "idle_quiet"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 0, 3, 0, 0, 0, "start_ready"));
        vecs.push_back(mk(0, 1, 0,  3, 1, 0, 3, 0, 0, 0, "ready_full_sec"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 0, 2, 0, 1, 0, "ready_2"));
        vecs.push_back(mk(0, 0, 0,  4, 1, 0, 1, 0, 1, 0, "ready_1"));
        vecs.push_back(mk(0, 0, 0,  4, 2, 1, 2, 1, 1, 0, "play_entry"));
        vecs.push_back(mk(0, 0, 0,  4, 2, 1, 1, 1, 1, 0, "play_11"));
        vecs.push_back(mk(0, 0, 0,  4, 2, 1, 0, 1, 1, 0, "play_10"));
        vecs.push_back(mk(0, 0, 0,  4, 2, 0, 9, 1, 1, 0, "borrow_09"));
        vecs.push_back(mk(0, 1, 0,  1, 2, 0, 9, 1, 0, 0, "play_start_hi"));
        vecs.push_back(mk(0, 0, 0,  1, 2, 0, 9, 1, 0, 0, "play_start_lo"));
        vecs.push_back(mk(0, 1, 0,  1, 2, 0, 9, 1, 0, 0, "play_start_hi2"));
        vecs.push_back(mk(0, 0, 0,  1, 2, 0, 8, 1, 1, 0, "play_phase_kept"));
        vecs.push_back(mk(0, 0, 0, 28, 2, 0, 1, 1, 1, 0, "play_01"));
        vecs.push_back(mk(0, 0, 0,  4, 3, 0, 0, 0, 1, 1, "time_up"));
        vecs.push_back(mk(0, 0, 0,  1, 3, 0, 0, 0, 0, 0, "time_up_once"));
        vecs.push_back(mk(0, 0, 0, 10, 3, 0, 0, 0, 0, 0, "over_hold"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 0, 3, 0, 0, 0, "over_restart"));
        vecs.push_back(mk(0, 1, 0, 12, 2, 1, 2, 1, 1, 0, "replay"));
        vecs.push_back(mk(0, 0, 0, 20, 2, 0, 7, 1, 1, 0, "play_07"));
        vecs.push_back(mk(1, 0, 0,  1, 0, 1, 2, 0, 0, 0, "mid_reset"));
        vecs.push_back(mk(0, 0, 0,  8, 0, 1, 2, 0, 0, 0, "post_reset_idle"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 0, 3, 0, 0, 0, "p_start"));
        vecs.push_back(mk(0, 1, 0, 12, 2, 1, 2, 1, 1, 0, "p_play"));
        vecs.push_back(mk(0, 1, 0, 28, 2, 0, 5, 1, 1, 0, "p_05"));
        vecs.push_back(mk(0, 1, 0,  2, 2, 0, 5, 1, 0, 0, "p_phase2"));
        if (PAUSE_EN) begin
            vecs.push_back(mk(0, 1, 1, 10, 2, 0, 5, 1, 0, 0, "pause_hold"));
            vecs.push_back(mk(0, 1, 0,  2, 2, 0, 4, 1, 1, 0, "pause_resume"));
        end else begin
            vecs.push_back(mk(0, 1, 1, 10, 2, 0, 2, 1, 1, 0, "pause_ignored"));
            vecs.push_back(mk(0, 1, 0,  2, 2, 0, 2, 1, 0, 0, "pause_after"));
        end

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                run_cycle(vecs[i].rst, vecs[i].start, vecs[i].pause, vecs[i].name);
            end
            check({"vec ", vecs[i].name}, dut_vec(),
                  {2'(vecs[i].st), 4'(vecs[i].tens), 4'(vecs[i].ones),
                   vecs[i].act, vecs[i].tk, vecs[i].tu});
        end

        // randomized run: slow Start toggling, bursts of Pause, rare resets
        begin
            bit s = 1'b0;
            bit p = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                bit r = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 15) == 0) s = ~s;
                if ($urandom_range(0, 9) == 0) p = ~p;
                run_cycle(r, s, p, "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
